// File: rtl/dec_pkg.sv
// Shared mode encoding for the scan decoder slice.
package dec_pkg;
  typedef enum logic {MODE_DIRECT = 1'b0, MODE_SCAN = 1'b1} mode_e;
endpackage

// File: rtl/onehot_dec.sv
// Combinational code -> one-hot decode with an out-of-range flag.
module onehot_dec #(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 8
) (
  input  logic [SEL_W-1:0]   sel,
  output logic [NUM_OUT-1:0] oh,
  output logic               err
);
  for (genvar i = 0; i < NUM_OUT; i++) begin : g_line
    assign oh[i] = (sel == SEL_W'(i));
  end

  // Exactly one line matches for any in-range code, so no match means out of range.
  assign err = ~|oh;
endmodule

// File: rtl/scan_decoder.sv
// Registered binary-to-one-hot decoder: handshaked DIRECT decode or a free-running
// SCAN walk across all lines with a programmable per-line dwell.
module scan_decoder
  import dec_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 8,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   in_sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_OUT-1:0] out,
  output logic               out_err,
  output logic               scan_wrap
);
  mode_e              mode_q;
  logic [SEL_W-1:0]   idx, idx_nxt, dec_sel;
  logic [DWELL_W-1:0] cnt;
  logic [NUM_OUT-1:0] dec_oh;
  logic               dec_err, scan, mode_chg, accept, last, adv;

  assign scan     = (mode == MODE_SCAN);
  assign mode_chg = (mode != mode_q);
  // On a SCAN->DIRECT switch the scan output is being discarded, so accept regardless.
  assign in_ready = !scan && (mode_chg || !out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign last     = (idx == SEL_W'(NUM_OUT - 1));
  assign idx_nxt  = last ? '0 : idx + SEL_W'(1);
  // >= so a dwell lowered mid-line still advances instead of running to wraparound.
  assign adv      = out_ready && (cnt >= dwell);
  assign dec_sel  = scan ? (mode_chg ? '0 : idx_nxt) : in_sel;

  onehot_dec #(.SEL_W(SEL_W), .NUM_OUT(NUM_OUT)) u_dec (
    .sel (dec_sel),
    .oh  (dec_oh),
    .err (dec_err)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q    <= MODE_DIRECT;
      idx       <= '0;
      cnt       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      scan_wrap <= 1'b0;
    end else begin
      mode_q    <= mode_e'(mode);
      scan_wrap <= 1'b0;
      if (scan) begin
        out_valid <= 1'b1;
        out_err   <= 1'b0;
        if (mode_chg) begin
          idx <= '0;
          cnt <= '0;
          out <= dec_oh;
        end else if (adv) begin
          idx       <= idx_nxt;
          cnt       <= '0;
          out       <= dec_oh;
          scan_wrap <= last;
        end else if (out_ready) begin
          cnt <= cnt + DWELL_W'(1);
        end
      end else begin
        idx <= '0;
        cnt <= '0;
        if (accept) begin
          out       <= dec_oh;
          out_err   <= dec_err;
          out_valid <= 1'b1;
        end else if (mode_chg) begin
          out       <= '0;
          out_err   <= 1'b0;
          out_valid <= 1'b0;
        end else if (out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder: 8-line main instance plus a 6-line instance for range errors.
module tb_scan_decoder;
  logic       clk = 1'b0;
  logic       rst_n, mode, in_valid, out_ready;
  logic [7:0] dwell;
  logic [2:0] in_sel;

  logic       in_ready, out_valid, out_err, scan_wrap;
  logic [7:0] out;
  logic       in_ready6, out_valid6, out_err6, scan_wrap6;
  logic [5:0] out6;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  scan_decoder #(.SEL_W(3), .NUM_OUT(8), .DWELL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .dwell(dwell),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .out_err(out_err), .scan_wrap(scan_wrap)
  );

  scan_decoder #(.SEL_W(3), .NUM_OUT(6), .DWELL_W(8)) dut6 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .dwell(dwell),
    .in_valid(in_valid), .in_ready(in_ready6), .in_sel(in_sel),
    .out_valid(out_valid6), .out_ready(out_ready), .out(out6),
    .out_err(out_err6), .scan_wrap(scan_wrap6)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] o, input logic v, input logic w);
    chk({tag, ".out"}, 32'(out), 32'(o));
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".wrap"}, 32'(scan_wrap), 32'(w));
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; in_valid = 1'b0; in_sel = 3'd0; out_ready = 1'b1; dwell = 8'd0;
    tick(); tick();
    chk_out("reset", 8'h00, 1'b0, 1'b0);
    chk("reset.err", 32'(out_err), 32'd0);
    chk("reset.valid6", 32'(out_valid6), 32'd0);
    rst_n = 1'b1;

    // DIRECT back-to-back, no bubbles
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_sel = 3'(i);
      #1 chk("b2b.in_ready", 32'(in_ready), 32'd1);
      tick();
      chk("b2b.out", 32'(out), 32'(8'h01 << i));
      chk("b2b.valid", 32'(out_valid), 32'd1);
      chk("b2b.err", 32'(out_err), 32'd0);
    end
    in_valid = 1'b0;
    tick();
    chk("drain.valid", 32'(out_valid), 32'd0);
    chk("drain.out_kept", 32'(out), 32'h80);

    // Out-of-range code on the 6-line instance
    in_valid = 1'b1; in_sel = 3'd6;
    tick();
    chk("range.out6", 32'(out6), 32'h00);
    chk("range.err6", 32'(out_err6), 32'd1);
    chk("range.valid6", 32'(out_valid6), 32'd1);
    chk("range.out8", 32'(out), 32'h40);
    chk("range.err8", 32'(out_err), 32'd0);
    in_sel = 3'd2;
    tick();
    chk("range2.out6", 32'(out6), 32'h04);
    chk("range2.err6", 32'(out_err6), 32'd0);
    in_valid = 1'b0;
    tick();
    chk("range3.valid6", 32'(out_valid6), 32'd0);

    // Backpressure hold
    in_valid = 1'b1; in_sel = 3'd3;
    tick();
    chk("bp.out", 32'(out), 32'h08);
    in_sel = 3'd5; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("bp.in_ready", 32'(in_ready), 32'd0);
      tick();
      chk("bp.hold", 32'(out), 32'h08);
      chk("bp.valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1 chk("bp.release_ready", 32'(in_ready), 32'd1);
    tick();
    chk("bp.next", 32'(out), 32'h20);
    in_valid = 1'b0;
    tick();
    chk("bp.drain", 32'(out_valid), 32'd0);

    // SCAN with dwell=2: 3 cycles per line, wrap pulse back to line 0
    mode = 1'b1; dwell = 8'd2; in_valid = 1'b1;
    #1 chk("scan.in_ready", 32'(in_ready), 32'd0);
    tick();
    for (int l = 0; l < 8; l++)
      for (int c = 0; c < 3; c++) begin
        chk_out("scan.walk", 8'h01 << l, 1'b1, 1'b0);
        chk("scan.err", 32'(out_err), 32'd0);
        tick();
      end
    chk_out("scan.wrap", 8'h01, 1'b1, 1'b1);
    tick();
    chk_out("scan.after_wrap", 8'h01, 1'b1, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("scan.stall", 8'h01, 1'b1, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    chk_out("scan.resume", 8'h01, 1'b1, 1'b0);
    tick();
    chk_out("scan.line1", 8'h02, 1'b1, 1'b0);

    // Walk to line 5, switch to DIRECT, then back
    for (int i = 0; i < 12; i++) tick();
    chk_out("sw.at5", 8'h20, 1'b1, 1'b0);
    mode = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1 chk("sw.in_ready", 32'(in_ready), 32'd1);
    tick();
    chk_out("sw.direct", 8'h00, 1'b0, 1'b0);
    out_ready = 1'b1; mode = 1'b1;
    tick();
    chk_out("sw.restart", 8'h01, 1'b1, 1'b0);
    tick(); tick();
    chk_out("sw.hold", 8'h01, 1'b1, 1'b0);
    tick();
    chk_out("sw.line1", 8'h02, 1'b1, 1'b0);

    // dwell=0: one cycle per line
    dwell = 8'd0;
    tick();
    chk_out("d0.a", 8'h04, 1'b1, 1'b0);
    tick();
    chk_out("d0.b", 8'h08, 1'b1, 1'b0);

    // Reset mid-scan
    rst_n = 1'b0;
    tick();
    chk_out("rst.scan", 8'h00, 1'b0, 1'b0);
    chk("rst.err", 32'(out_err), 32'd0);
    rst_n = 1'b1;
    tick();
    chk_out("rst.resume", 8'h01, 1'b1, 1'b0);
    tick();
    chk_out("rst.next", 8'h02, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
